// File: rtl/aggregate_readings.sv
`default_nettype none
// ============================================================================
//  Module   : aggregate_readings
//  Purpose  : Reads a sample count and that many 16-bit readings from the
//             shared register memory. Computes their sum and unsigned maximum,
//             writes both back into the register bank, then raises a sticky
//             done flag. When forAggregation is low at start, the block does
//             no memory traffic and only reports completion.
//  Ports    : clock          - single clock, rising edge
//             rst            - synchronous active-high reset
//             start          - begin operation (sampled only in IDLE)
//             forAggregation - upstream qualifier, sampled with start
//             data_in[15:0]  - memory read data, valid one cycle after address
//             address[15:0]  - registered memory address
//             data_out[15:0] - registered write data
//             wr_en          - write strobe, one cycle per write
//             sum_out[15:0]  - final sum (registered)
//             max_out[15:0]  - final maximum (registered)
//             done           - sticky completion flag
//  Config   : AGG_SATURATE_EN defined  -> sum clamps at 16'hFFFF
//             AGG_SATURATE_EN undefined -> sum wraps modulo 2^16
//  Revision : 1.0 - initial release
// ============================================================================
module aggregate_readings #(
  parameter logic [15:0] CNT_ADDR  = 16'h0001,
  parameter logic [15:0] DATA_BASE = 16'h0002,
  parameter logic [15:0] SUM_ADDR  = 16'h0010,
  parameter logic [15:0] MAX_ADDR  = 16'h0011,
  parameter int          MAX_COUNT = 64
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic        forAggregation,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic [15:0] data_out,
  output logic        wr_en,
  output logic [15:0] sum_out,
  output logic [15:0] max_out,
  output logic        done
);

  localparam logic [15:0] MAX_CNT16 = 16'(MAX_COUNT);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ_CNT = 3'd1;
  localparam logic [2:0] LD_CNT  = 3'd2;
  localparam logic [2:0] REQ     = 3'd3;
  localparam logic [2:0] ACC     = 3'd4;
  localparam logic [2:0] WR_SUM  = 3'd5;
  localparam logic [2:0] WR_MAX  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  logic [2:0]  state, state_nxt;
  logic [15:0] count, count_nxt;
  logic [15:0] index, index_nxt;
  logic [15:0] sum, sum_nxt;
  logic [15:0] max, max_nxt;
  logic [15:0] address_nxt, data_out_nxt, sum_out_nxt, max_out_nxt;
  logic        wr_en_nxt, done_nxt;

  logic [15:0] count_clamped;
  logic [15:0] index_inc;
  logic [16:0] sum_wide;
  logic [15:0] sum_acc;

  assign count_clamped = (data_in > MAX_CNT16) ? MAX_CNT16 : data_in;
  assign index_inc     = index + 16'd1;
  assign sum_wide      = {1'b0, sum} + {1'b0, data_in};

`ifdef AGG_SATURATE_EN
  // A carry out means the true sum exceeded 16 bits; pin it at all-ones.
  // Readings are unsigned, so once pinned it can never come back down.
  assign sum_acc = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
`else
  assign sum_acc = sum_wide[15:0];
`endif

  // State register and all registered datapath/outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      count    <= 16'd0;
      index    <= 16'd0;
      sum      <= 16'd0;
      max      <= 16'd0;
      address  <= 16'd0;
      data_out <= 16'd0;
      wr_en    <= 1'b0;
      sum_out  <= 16'd0;
      max_out  <= 16'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      index    <= index_nxt;
      sum      <= sum_nxt;
      max      <= max_nxt;
      address  <= address_nxt;
      data_out <= data_out_nxt;
      wr_en    <= wr_en_nxt;
      sum_out  <= sum_out_nxt;
      max_out  <= max_out_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = forAggregation ? REQ_CNT : DONE;
      REQ_CNT: state_nxt = LD_CNT;
      LD_CNT:  state_nxt = (count_clamped == 16'd0) ? WR_SUM : REQ;
      REQ:     state_nxt = ACC;
      ACC:     state_nxt = (index_inc < count) ? REQ : WR_SUM;
      WR_SUM:  state_nxt = WR_MAX;
      WR_MAX:  state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic. Outputs are registered, so the values loaded on
  // entry to a state are chosen from state_nxt; the write data therefore
  // already includes the reading accumulated on the final ACC edge.
  always_comb begin
    count_nxt    = count;
    index_nxt    = index;
    sum_nxt      = sum;
    max_nxt      = max;
    address_nxt  = address;
    data_out_nxt = data_out;
    wr_en_nxt    = 1'b0;
    sum_out_nxt  = sum_out;
    max_out_nxt  = max_out;
    done_nxt     = done;

    case (state)
      IDLE: begin
        if (start) begin
          sum_nxt = 16'd0;
          max_nxt = 16'd0;
          if (forAggregation) address_nxt = CNT_ADDR;
        end
      end
      LD_CNT: begin
        count_nxt = count_clamped;
        if (count_clamped != 16'd0) begin
          index_nxt   = 16'd0;
          address_nxt = DATA_BASE;
        end
      end
      ACC: begin
        sum_nxt   = sum_acc;
        max_nxt   = (data_in > max) ? data_in : max;
        index_nxt = index_inc;
        if (index_inc < count) address_nxt = DATA_BASE + index_inc;
      end
      default: ;
    endcase

    case (state_nxt)
      WR_SUM: begin
        address_nxt  = SUM_ADDR;
        data_out_nxt = sum_nxt;
        wr_en_nxt    = 1'b1;
      end
      WR_MAX: begin
        address_nxt  = MAX_ADDR;
        data_out_nxt = max_nxt;
        wr_en_nxt    = 1'b1;
      end
      DONE: begin
        done_nxt    = 1'b1;
        sum_out_nxt = sum_nxt;
        max_out_nxt = max_nxt;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
